// File: rtl/pipe_skid_if.sv
// Handshake bundle for one skid-buffered pipeline stage: upstream (in_*) and downstream (out_*) sides.
interface pipe_skid_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy
  );

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Generic 2-entry skid-buffer pipeline stage with valid/ready handshake, flush and NOP-on-bubble.
module pipe_skid_reg #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned CTRL_W     = 8,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  pipe_skid_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t state, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   accept;
  logic   retire;
  logic   in_ready_int;
  logic   main_valid;

  assign in_ready_int = (state != FULL);
  assign main_valid   = (state != EMPTY);
  assign in_entry     = '{ctrl: bus.in_ctrl, data: bus.in_data};
  assign accept       = bus.in_valid & in_ready_int;
  assign retire       = main_valid & bus.out_ready;

  // State and entry registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  always_comb begin
    state_d = state;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          main_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && retire) begin
          main_d = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = FULL;
        end else if (retire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (retire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush drops anything accepted this cycle; the held payload stays for the hold-data build.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    // Bubble: present a NOP downstream.
    if (state_d == EMPTY) begin
      main_d.ctrl = '0;
      if (CLEAR_DATA) begin
        main_d.data = '0;
      end
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_q.data;
  assign bus.out_ctrl  = main_q.ctrl;
  assign bus.occupancy = state;

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised successor to the fixed-field EX/MEM stage register; one generic pipeline stage between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the single-entry stall-inserts-NOP register with a 2-entry skid buffer carrying a valid/ready handshake.
- Sustains full throughput under back-pressure, keeps FIFO order, supports synchronous flush, and zeroes control bits on bubbles so downstream logic sees a NOP.

Parameters:
- DATA_W, 64: payload width (e.g. ALU result and rs2 data).
- CTRL_W, 8: control-field width (memtoreg, regwrite, memread, memwrite, rd, ...); forced to 0 whenever the output is not valid.
- CLEAR_DATA, 1: 1 = out_data forced to 0 on bubble; 0 = out_data holds its last value on bubble.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage can accept; equals (occupancy != 2), combinational from state only.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control field.
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  main-entry payload.
- out_ctrl  out  CTRL_W  main-entry control; 0 when out_valid=0.
- occupancy  out  2  number of held entries, 0..2.

Behaviour:
- Storage: main entry (drives the outputs) and skid entry. State EMPTY(0), ONE(1), FULL(2); occupancy is the state encoding.
- Definitions: accept = in_valid & in_ready; retire = out_valid & out_ready.
- Reset (reset=0, asynchronous):
  - state EMPTY; both entries' data and ctrl = 0.
  - Outputs: out_valid=0, out_data=0, out_ctrl=0, occupancy=0, in_ready=1.
  - Reset asserted mid-transfer discards all entries immediately.
- EMPTY:
  - accept -> main <= input, go to ONE.
  - Latency: input presented in cycle N appears at the outputs in cycle N+1.
- ONE:
  - accept & retire -> main <= input, stay ONE.
  - accept & !retire -> skid <= input, go to FULL.
  - !accept & retire -> go to EMPTY.
  - neither -> hold.
- FULL:
  - in_ready=0, so accept is impossible.
  - retire -> main <= skid, go to ONE.
  - !retire -> hold both entries unchanged.
- Order: entries retire strictly in accept order. No entry is duplicated or lost except by flush or reset.
- Flush (priority over every other event):
  - Next state EMPTY; both entries invalidated; ctrl cleared.
  - An input accepted in the flush cycle is dropped.
  - A retire in the flush cycle still completes downstream, since out_valid was 1 that cycle.
- Bubble: whenever out_valid=0, out_ctrl=0. out_data=0 if CLEAR_DATA=1, else it holds its last value.
- Data path: pure register; no width conversion or arithmetic. Skid-entry contents are don't-care when the skid entry is not valid.
- Handshake rules:
  - in_data/in_ctrl are sampled only on accept.
  - out_data/out_ctrl are stable while out_valid=1 and out_ready=0.
  - in_ready has no combinational dependence on out_ready (no ready path through the stage).

Test Plan:
- Reset then idle: reset low 3 cycles, release, hold in_valid=0 -> out_valid=0, out_ctrl=0x00, out_data=0, in_ready=1, occupancy=0 throughout.
- Streaming: out_ready=1, in_valid=1 for data 1..8 on consecutive cycles -> out_data=1..8 on cycles N+1..N+8; occupancy stays 1; in_ready never 0.
- Back-pressure: stream A,B,C with out_ready=0 from the 2nd cycle -> occupancy 1 then 2, in_ready=0, C held upstream. Release out_ready -> A, B, C emerge in order, no loss or duplication.
- Flush while FULL: hold 0x11 and 0x22, assert flush with in_valid=1 carrying 0x33 -> next cycle occupancy=0, out_valid=0, out_ctrl=0; 0x33 never appears.
- Async reset mid-stream: reset pulsed low between clock edges while FULL -> outputs cleared immediately, before the next edge; stream restarts cleanly after release.
- CLEAR_DATA=0 build: retire last entry 0xABCD, then idle -> out_valid=0, out_ctrl=0, out_data remains 0xABCD.
